// File: rtl/hp_fifo.sv
// Host-to-parasite byte FIFO for the Tube register 3 data path: first-word-fall-through,
// edge-qualified strobes, one/two-byte occupancy mode, host full flag and parasite NMI.
module hp_fifo #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [7:0]  EMPTY_DATA = 8'hAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_wr,
    input  logic [7:0] h_data,
    input  logic       h_flush,
    input  logic       h_one_byte,
    output logic       h_full,
    input  logic       p_rd,
    input  logic       p_nmi_en,
    output logic [7:0] p_data,
    output logic       p_data_available,
    output logic       p_nmi
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          h_wr_q, h_wr_d;
    logic          p_rd_q, p_rd_d;
    logic          p_nmi_q, p_nmi_d;

    logic [CW-1:0] cap;
    logic          push_req, pop_req;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        // Explicit wrap so non-power-of-two depths stay inside the array.
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign cap      = h_one_byte ? CW'(1) : CW'(DEPTH);
    assign push_req = h_wr & ~h_wr_q;
    assign pop_req  = p_rd & ~p_rd_q;
    assign pop_ok   = pop_req & (count_q != '0) & ~h_flush;
    assign push_ok  = push_req & ((count_q < cap) | pop_ok) & ~h_flush;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        h_wr_d   = h_wr;
        p_rd_d   = p_rd;

        if (h_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        p_nmi_d = p_nmi_en & (count_d >= cap);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            h_wr_q   <= 1'b0;
            p_rd_q   <= 1'b0;
            p_nmi_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            h_wr_q   <= h_wr_d;
            p_rd_q   <= p_rd_d;
            p_nmi_q  <= p_nmi_d;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read so stale bytes never show.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= h_data;
    end

    assign h_full           = (count_q >= cap);
    assign p_data_available = (count_q != '0);
    assign p_data           = (count_q == '0) ? EMPTY_DATA : mem_q[rd_ptr_q];
    assign p_nmi            = p_nmi_q;

endmodule

// File: tb/tb_hp_fifo.sv
// Directed self-checking bench for hp_fifo (DEPTH=2): one task per scenario with inline checks.
module tb_hp_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       h_wr;
    logic [7:0] h_data;
    logic       h_flush;
    logic       h_one_byte;
    logic       h_full;
    logic       p_rd;
    logic       p_nmi_en;
    logic [7:0] p_data;
    logic       p_data_available;
    logic       p_nmi;

    int checks = 0;
    int errors = 0;

    hp_fifo #(.DEPTH(2), .EMPTY_DATA(8'hAA)) dut (
        .clk              (clk),
        .rst              (rst),
        .h_wr             (h_wr),
        .h_data           (h_data),
        .h_flush          (h_flush),
        .h_one_byte       (h_one_byte),
        .h_full           (h_full),
        .p_rd             (p_rd),
        .p_nmi_en         (p_nmi_en),
        .p_data           (p_data),
        .p_data_available (p_data_available),
        .p_nmi            (p_nmi)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        h_data = d;
        h_wr   = 1'b1;
        tick();
        h_wr   = 1'b0;
        tick();
    endtask

    task automatic pop();
        p_rd = 1'b1;
        tick();
        p_rd = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; h_wr = 1'b0; h_data = 8'h00; h_flush = 1'b0;
        h_one_byte = 1'b0; p_rd = 1'b0; p_nmi_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL reset_p_data cyc%0d: got %h expected aa", i, p_data); end
            checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL reset_avail cyc%0d: got %b expected 0", i, p_data_available); end
            checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL reset_full cyc%0d: got %b expected 0", i, h_full); end
            checks++; if (p_nmi !== 1'b0) begin errors++; $display("FAIL reset_nmi cyc%0d: got %b expected 0", i, p_nmi); end
        end
    endtask

    task automatic test_two_byte();
        h_one_byte = 1'b0; p_nmi_en = 1'b1;
        push(8'h12);
        checks++; if (p_data_available !== 1'b1) begin errors++; $display("FAIL two_avail1: got %b expected 1", p_data_available); end
        checks++; if (p_data !== 8'h12) begin errors++; $display("FAIL two_head1: got %h expected 12", p_data); end
        checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL two_full1: got %b expected 0", h_full); end
        checks++; if (p_nmi !== 1'b0) begin errors++; $display("FAIL two_nmi1: got %b expected 0", p_nmi); end
        push(8'h34);
        checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL two_full2: got %b expected 1", h_full); end
        checks++; if (p_nmi !== 1'b1) begin errors++; $display("FAIL two_nmi2: got %b expected 1", p_nmi); end
        push(8'h56);
        checks++; if (p_data !== 8'h12) begin errors++; $display("FAIL two_head_after_discard: got %h expected 12", p_data); end
        checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL two_full3: got %b expected 1", h_full); end
        pop();
        checks++; if (p_data !== 8'h34) begin errors++; $display("FAIL two_pop1: got %h expected 34", p_data); end
        checks++; if (p_nmi !== 1'b0) begin errors++; $display("FAIL two_nmi_pop1: got %b expected 0", p_nmi); end
        checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL two_full_pop1: got %b expected 0", h_full); end
        pop();
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL two_pop2: got %h expected aa", p_data); end
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL two_avail_pop2: got %b expected 0", p_data_available); end
        pop();
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL two_pop_empty: got %h expected aa", p_data); end
    endtask

    task automatic test_held_strobes();
        h_data = 8'h77; h_wr = 1'b1;
        repeat (10) tick();
        h_wr = 1'b0;
        tick();
        checks++; if (p_data_available !== 1'b1) begin errors++; $display("FAIL held_avail: got %b expected 1", p_data_available); end
        checks++; if (p_data !== 8'h77) begin errors++; $display("FAIL held_head: got %h expected 77", p_data); end
        checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL held_full: got %b expected 0", h_full); end
        p_rd = 1'b1;
        repeat (10) tick();
        p_rd = 1'b0;
        tick();
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL held_pop_avail: got %b expected 0", p_data_available); end
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL held_pop_data: got %h expected aa", p_data); end
    endtask

    task automatic test_one_byte();
        h_one_byte = 1'b1;
        push(8'hA5);
        checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL one_full: got %b expected 1", h_full); end
        checks++; if (p_nmi !== 1'b1) begin errors++; $display("FAIL one_nmi: got %b expected 1", p_nmi); end
        push(8'h5A);
        checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL one_discard: got %h expected a5", p_data); end
        pop();
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL one_pop: got %h expected aa", p_data); end
        checks++; if (p_nmi !== 1'b0) begin errors++; $display("FAIL one_pop_nmi: got %b expected 0", p_nmi); end
        h_one_byte = 1'b0;
    endtask

    task automatic test_mode_switch();
        push(8'h21);
        push(8'h22);
        h_one_byte = 1'b1;
        push(8'h23);
        checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL sw_full2: got %b expected 1", h_full); end
        pop();
        checks++; if (p_data !== 8'h22) begin errors++; $display("FAIL sw_pop1: got %h expected 22", p_data); end
        checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL sw_full1: got %b expected 1", h_full); end
        checks++; if (p_nmi !== 1'b1) begin errors++; $display("FAIL sw_nmi1: got %b expected 1", p_nmi); end
        pop();
        checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL sw_full0: got %b expected 0", h_full); end
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL sw_empty: got %h expected aa", p_data); end
        h_one_byte = 1'b0;
    endtask

    task automatic test_back_to_back();
        push(8'h01);
        push(8'h02);
        checks++; if (p_data !== 8'h01) begin errors++; $display("FAIL b2b_head: got %h expected 01", p_data); end
        h_data = 8'h03; h_wr = 1'b1; p_rd = 1'b1;
        tick();
        h_wr = 1'b0; p_rd = 1'b0;
        tick();
        checks++; if (p_data !== 8'h02) begin errors++; $display("FAIL b2b_after: got %h expected 02", p_data); end
        checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b expected 1", h_full); end
        checks++; if (p_nmi !== 1'b1) begin errors++; $display("FAIL b2b_nmi: got %b expected 1", p_nmi); end
        pop();
        checks++; if (p_data !== 8'h03) begin errors++; $display("FAIL b2b_pop2: got %h expected 03", p_data); end
        pop();
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", p_data_available); end
        h_data = 8'h03; h_wr = 1'b1; p_rd = 1'b1;
        tick();
        h_wr = 1'b0; p_rd = 1'b0;
        tick();
        checks++; if (p_data_available !== 1'b1) begin errors++; $display("FAIL b2b_empty_avail: got %b expected 1", p_data_available); end
        checks++; if (p_data !== 8'h03) begin errors++; $display("FAIL b2b_empty_data: got %h expected 03", p_data); end
        checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL b2b_empty_full: got %b expected 0", h_full); end
        pop();
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL b2b_drain: got %h expected aa", p_data); end
    endtask

    task automatic test_flush();
        push(8'hAB);
        push(8'hCD);
        h_data = 8'hEF; h_wr = 1'b1; h_flush = 1'b1;
        tick();
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL flush_avail: got %b expected 0", p_data_available); end
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL flush_data: got %h expected aa", p_data); end
        checks++; if (p_nmi !== 1'b0) begin errors++; $display("FAIL flush_nmi: got %b expected 0", p_nmi); end
        h_wr = 1'b0; h_flush = 1'b0;
        tick();
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL flush_settle: got %b expected 0", p_data_available); end
        push(8'h99);
        checks++; if (p_data !== 8'h99) begin errors++; $display("FAIL flush_repush: got %h expected 99", p_data); end
        pop();
    endtask

    task automatic test_reset_mid();
        push(8'h44);
        push(8'h55);
        h_data = 8'h66; h_wr = 1'b1; rst = 1'b1;
        tick();
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL rst_avail: got %b expected 0", p_data_available); end
        checks++; if (p_data !== 8'hAA) begin errors++; $display("FAIL rst_data: got %h expected aa", p_data); end
        checks++; if (p_nmi !== 1'b0) begin errors++; $display("FAIL rst_nmi: got %b expected 0", p_nmi); end
        checks++; if (h_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", h_full); end
        h_wr = 1'b0; rst = 1'b0;
        tick();
        checks++; if (p_data_available !== 1'b0) begin errors++; $display("FAIL rst_release: got %b expected 0", p_data_available); end
        push(8'h88);
        checks++; if (p_data !== 8'h88) begin errors++; $display("FAIL rst_repush: got %h expected 88", p_data); end
    endtask

    initial begin
        test_reset();
        test_two_byte();
        test_held_strobes();
        test_one_byte();
        test_mode_switch();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
